// File: rtl/data_port_arbiter.sv
// Round-robin arbiter sharing one single-cycle data-memory port between the CPU and a debug/load master.
// Grant is combinational; ownership, burst lock, stall counter and protocol error are registered.
//
// owner state | meaning
// ------------+---------------------------------------------------------------
// OWN_NONE    | no master was granted last cycle (also the reset state)
// OWN_CPU     | CPU was granted last cycle; may keep the port under burst lock
// OWN_DBG     | debug master was granted last cycle; may keep the port under lock

module data_port_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int STALL_W   = 16
) (
    input  logic               clk,
    input  logic               reset,

    input  logic [31:0]        cpu_address,
    input  logic               cpu_read,
    input  logic               cpu_write,
    input  logic [31:0]        cpu_writedata,
    output logic [31:0]        cpu_readdata,
    output logic               cpu_waitrequest,

    input  logic [31:0]        dbg_address,
    input  logic               dbg_read,
    input  logic               dbg_write,
    input  logic [31:0]        dbg_writedata,
    output logic [31:0]        dbg_readdata,
    output logic               dbg_waitrequest,

    output logic [31:0]        mem_address,
    output logic               mem_read,
    output logic               mem_write,
    output logic [31:0]        mem_writedata,
    input  logic [31:0]        mem_readdata,

    output logic [STALL_W-1:0] cpu_stall_cnt,
    output logic               protocol_err
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    owner_t             owner_q, owner_d;
    owner_t             grant;
    logic [3:0]         burst_cnt_q, burst_cnt_d;
    logic               last_dbg_q, last_dbg_d;
    logic [STALL_W-1:0] cpu_stall_cnt_q, cpu_stall_cnt_d;
    logic               protocol_err_q, protocol_err_d;

    logic               cpu_req;
    logic               dbg_req;
    logic               sel_read;
    logic               sel_write;

    assign cpu_req = cpu_read | cpu_write;
    assign dbg_req = dbg_read | dbg_write;

    // Reset low forces NONE so an in-flight write is dropped asynchronously.
    always_comb begin
        grant = OWN_NONE;
        if (!reset) begin
            grant = OWN_NONE;
        end else if (cpu_req && !dbg_req) begin
            grant = OWN_CPU;
        end else if (dbg_req && !cpu_req) begin
            grant = OWN_DBG;
        end else if (cpu_req && dbg_req) begin
            if (owner_q != OWN_NONE && burst_cnt_q < BURST_LAST) begin
                grant = owner_q;
            end else begin
                grant = last_dbg_q ? OWN_CPU : OWN_DBG;
            end
        end
    end

    always_comb begin
        mem_address     = 32'h0;
        mem_writedata   = 32'h0;
        sel_read        = 1'b0;
        sel_write       = 1'b0;
        cpu_readdata    = 32'h0;
        dbg_readdata    = 32'h0;
        cpu_waitrequest = cpu_req;
        dbg_waitrequest = dbg_req;
        case (grant)
            OWN_CPU: begin
                mem_address     = cpu_address;
                mem_writedata   = cpu_writedata;
                sel_read        = cpu_read;
                sel_write       = cpu_write;
                cpu_readdata    = mem_readdata;
                cpu_waitrequest = 1'b0;
            end
            OWN_DBG: begin
                mem_address     = dbg_address;
                mem_writedata   = dbg_writedata;
                sel_read        = dbg_read;
                sel_write       = dbg_write;
                dbg_readdata    = mem_readdata;
                dbg_waitrequest = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // A simultaneous read+write from the granted master is treated as a write.
    assign mem_read  = sel_read & ~sel_write;
    assign mem_write = sel_write;

    always_comb begin
        owner_d         = grant;
        burst_cnt_d     = 4'd0;
        last_dbg_d      = last_dbg_q;
        cpu_stall_cnt_d = cpu_stall_cnt_q;
        protocol_err_d  = protocol_err_q;

        if (grant == owner_q && grant != OWN_NONE) begin
            burst_cnt_d = (burst_cnt_q < BURST_LAST) ? burst_cnt_q + 4'd1 : BURST_LAST;
        end

        if (grant != OWN_NONE) begin
            last_dbg_d = (grant == OWN_DBG);
        end

        if (cpu_waitrequest && !(&cpu_stall_cnt_q)) begin
            cpu_stall_cnt_d = cpu_stall_cnt_q + STALL_W'(1);
        end

        if (sel_read && sel_write) begin
            protocol_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q         <= OWN_NONE;
            burst_cnt_q     <= 4'd0;
            last_dbg_q      <= 1'b1;
            cpu_stall_cnt_q <= '0;
            protocol_err_q  <= 1'b0;
        end else begin
            owner_q         <= owner_d;
            burst_cnt_q     <= burst_cnt_d;
            last_dbg_q      <= last_dbg_d;
            cpu_stall_cnt_q <= cpu_stall_cnt_d;
            protocol_err_q  <= protocol_err_d;
        end
    end

    assign cpu_stall_cnt = cpu_stall_cnt_q;
    assign protocol_err  = protocol_err_q;

endmodule
